// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - shared state encoding for the keypad door-lock manager
package lock_pkg;

    // Display/actuator logic decodes these values directly; keep them stable.
    typedef enum logic [2:0] {
        ST_OFF   = 3'b000,
        ST_ON    = 3'b001,
        ST_WRONG = 3'b010,
        ST_OPEN  = 3'b100,
        ST_REKEY = 3'b101,
        ST_LOCK  = 3'b111
    } lock_state_e;

    function automatic logic state_is_valid(input logic [2:0] s);
        return (s == ST_OFF)  || (s == ST_ON)    || (s == ST_WRONG) ||
               (s == ST_OPEN) || (s == ST_REKEY) || (s == ST_LOCK);
    endfunction

endpackage

// File: rtl/tick_divider.sv
// rtl/tick_divider.sv - free-running divider producing a one-cycle decision strobe
module tick_divider #(
    parameter int SAMPLE_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [DIV_W-1:0] LAST = DIV_W'(SAMPLE_DIV - 1);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lock_fsm_param.sv
// rtl/lock_fsm_param.sv - tick-sampled door-lock state manager with lockout and timed relock
module lock_fsm_param
    import lock_pkg::*;
#(
    parameter int SAMPLE_DIV = 50000,
    parameter int MAX_TRIES  = 3,
    parameter int LOCK_TICKS = 0,
    parameter int OPEN_TICKS = 0,
    parameter int CNT_W      = $clog2(MAX_TRIES + 1),
    parameter int TMR_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             is_on,
    input  logic             star_pressed,
    input  logic             rekey,
    input  logic             correct,
    input  logic             initialize,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] attempts_left,
    output logic             tick,
    output logic             unlock_pulse,
    output logic             lockout_pulse,
    output logic             rekey_done_pulse
);

    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_TRIES);
    localparam logic [TMR_W-1:0] LOCK_INIT = TMR_W'(LOCK_TICKS);
    localparam logic [TMR_W-1:0] OPEN_INIT = TMR_W'(OPEN_TICKS);

    lock_state_e      state_q, state_d;
    logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
    logic [CNT_W-1:0] attempts_left_q, attempts_left_d;
    logic [TMR_W-1:0] lock_tmr_q, lock_tmr_d;
    logic [TMR_W-1:0] open_tmr_q, open_tmr_d;
    logic             star_prev_q, star_prev_d;
    logic             star_pend_q, star_pend_d;
    logic             unlock_q, unlock_d;
    logic             lockout_q, lockout_d;
    logic             rekey_done_q, rekey_done_d;
    logic             star_edge;

    tick_divider #(
        .SAMPLE_DIV(SAMPLE_DIV)
    ) u_tick_divider (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    // A press landing in the tick cycle itself is kept for the following tick.
    always_comb begin
        star_edge   = star_pressed & ~star_prev_q;
        star_prev_d = star_pressed;
        if (star_edge) begin
            star_pend_d = 1'b1;
        end else if (tick) begin
            star_pend_d = 1'b0;
        end else begin
            star_pend_d = star_pend_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        fail_cnt_d   = fail_cnt_q;
        lock_tmr_d   = lock_tmr_q;
        open_tmr_d   = open_tmr_q;
        unlock_d     = 1'b0;
        lockout_d    = 1'b0;
        rekey_done_d = 1'b0;

        if (tick) begin
            if (initialize) begin
                state_d    = ST_OFF;
                fail_cnt_d = '0;
                lock_tmr_d = '0;
                open_tmr_d = '0;
            end else begin
                case (state_q)
                    ST_LOCK: begin
                        if (LOCK_TICKS > 0) begin
                            if (lock_tmr_q <= TMR_W'(1)) begin
                                state_d    = ST_OFF;
                                fail_cnt_d = '0;
                                lock_tmr_d = '0;
                            end else begin
                                lock_tmr_d = lock_tmr_q - TMR_W'(1);
                            end
                        end
                    end
                    ST_OFF: begin
                        if (is_on) begin
                            state_d = (fail_cnt_q == '0) ? ST_ON : ST_WRONG;
                        end
                    end
                    ST_ON, ST_WRONG: begin
                        // Powering down keeps the count so cycling is not a free retry.
                        if (!is_on) begin
                            state_d = ST_OFF;
                        end else if (star_pend_q) begin
                            if (correct) begin
                                state_d    = ST_OPEN;
                                fail_cnt_d = '0;
                                open_tmr_d = OPEN_INIT;
                                unlock_d   = 1'b1;
                            end else if (fail_cnt_q + CNT_W'(1) == MAX_CNT) begin
                                state_d    = ST_LOCK;
                                fail_cnt_d = MAX_CNT;
                                lock_tmr_d = LOCK_INIT;
                                lockout_d  = 1'b1;
                            end else begin
                                state_d    = ST_WRONG;
                                fail_cnt_d = fail_cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    ST_OPEN: begin
                        if (rekey) begin
                            state_d    = ST_REKEY;
                            open_tmr_d = '0;
                        end else if (OPEN_TICKS > 0) begin
                            if (open_tmr_q <= TMR_W'(1)) begin
                                state_d    = ST_OFF;
                                open_tmr_d = '0;
                            end else begin
                                open_tmr_d = open_tmr_q - TMR_W'(1);
                            end
                        end
                    end
                    ST_REKEY: begin
                        if (star_pend_q && correct) begin
                            state_d      = ST_OFF;
                            rekey_done_d = 1'b1;
                        end
                    end
                    default: begin
                        state_d = ST_OFF;
                    end
                endcase
            end
        end

        attempts_left_d = MAX_CNT - fail_cnt_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_OFF;
            fail_cnt_q      <= '0;
            attempts_left_q <= MAX_CNT;
            lock_tmr_q      <= '0;
            open_tmr_q      <= '0;
            star_prev_q     <= 1'b0;
            star_pend_q     <= 1'b0;
            unlock_q        <= 1'b0;
            lockout_q       <= 1'b0;
            rekey_done_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            fail_cnt_q      <= fail_cnt_d;
            attempts_left_q <= attempts_left_d;
            lock_tmr_q      <= lock_tmr_d;
            open_tmr_q      <= open_tmr_d;
            star_prev_q     <= star_prev_d;
            star_pend_q     <= star_pend_d;
            unlock_q        <= unlock_d;
            lockout_q       <= lockout_d;
            rekey_done_q    <= rekey_done_d;
        end
    end

    assign state            = state_q;
    assign fail_cnt         = fail_cnt_q;
    assign attempts_left    = attempts_left_q;
    assign unlock_pulse     = unlock_q;
    assign lockout_pulse    = lockout_q;
    assign rekey_done_pulse = rekey_done_q;

endmodule

// File: doc/lock_fsm_param.md
Name: lock_fsm_param

Overview:
Parametrised successor to the keypad door-lock state manager. It samples user/keypad controls on a divided tick and runs the off/on/wrong/open/rekey/lock sequence. New versus the previous generation: configurable attempt limit, timed auto-unlock from lockout, timed auto-relock from open, a latched star edge that is never lost or double-counted, and status/event outputs. It sits between the keypad/compare logic (which drives correct) and the display/actuator logic.

Parameters:
SAMPLE_DIV, 50000, clk cycles per decision tick (>=1; 1 = tick every cycle)
MAX_TRIES, 3, wrong entries before lockout (>=1)
LOCK_TICKS, 0, ticks spent in LOCK before auto-return to OFF; 0 = permanent until initialize
OPEN_TICKS, 0, ticks spent in OPEN before auto-relock to OFF; 0 = stays open
CNT_W, $clog2(MAX_TRIES+1), width of fail counter (derived)
TMR_W, 16, width of lock/open timers (must hold max(LOCK_TICKS,OPEN_TICKS))

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
is_on  in  1  toggled power/arm level (# key)
star_pressed  in  1  raw star key level
rekey  in  1  change-code button level
correct  in  1  entered code matches (in REKEY: new code valid)
initialize  in  1  master clear level
state  out  3  000 OFF, 001 ON, 010 WRONG, 100 OPEN, 101 REKEY, 111 LOCK
fail_cnt  out  CNT_W  consecutive wrong entries
attempts_left  out  CNT_W  MAX_TRIES - fail_cnt
tick  out  1  one-cycle decision strobe
unlock_pulse  out  1  one cycle, on entry to OPEN
lockout_pulse  out  1  one cycle, on entry to LOCK
rekey_done_pulse  out  1  one cycle, on REKEY -> OFF

Behaviour:
- Reset (rst_n=0, async): state=000, fail_cnt=0, attempts_left=MAX_TRIES, timers=0, divider=0, star latch=0, all pulses=0.
- Divider counts 0..SAMPLE_DIV-1. tick=1 on the cycle it equals SAMPLE_DIV-1, then it wraps to 0. First tick falls SAMPLE_DIV cycles after reset release.
- Star: star_prev registered every clk. A rising edge sets star_pend. star_pend clears on every tick, whether consumed or discarded. An edge in the tick cycle itself sets star_pend for the next tick (set wins). A held key counts once.
- State changes only on tick cycles. Priority, highest first:
  1. initialize=1 -> OFF; fail_cnt=0; timers=0.
  2. LOCK: if LOCK_TICKS>0, decrement lock timer; at 0 -> OFF, fail_cnt=0. Other inputs are ignored.
  3. OFF with is_on=1 -> ON if fail_cnt=0, else WRONG.
  4. ON/WRONG with is_on=0 -> OFF. fail_cnt is retained (power-cycling does not clear attempts).
  5. ON/WRONG with star_pend:
     - correct=1 -> OPEN; fail_cnt=0; open timer=OPEN_TICKS; unlock_pulse.
     - correct=0 and fail_cnt+1=MAX_TRIES -> LOCK; fail_cnt=MAX_TRIES; lock timer=LOCK_TICKS; lockout_pulse.
     - correct=0 otherwise -> WRONG; fail_cnt+1.
  6. OPEN: rekey=1 -> REKEY (rekey beats timer). Else if OPEN_TICKS>0, decrement; at 0 -> OFF.
  7. REKEY: star_pend with correct=1 -> OFF; rekey_done_pulse. With correct=0 -> stay, no count.
- Otherwise the state holds. Pulses are combinational-free registered one-cycle outputs aligned to the cycle after the tick. attempts_left is registered consistently with fail_cnt.
- Unused encodings 011/110 -> OFF on next tick.

Decomposition:
- Shared package lock_pkg: state encoding constants (ST_OFF, ST_ON, ST_WRONG, ST_OPEN, ST_REKEY, ST_LOCK) for display/actuator consumers.
- One sub-module tick_divider (parameter SAMPLE_DIV; ports clk, rst_n, tick). It is reusable by the keypad scanner.

Test Plan:
(All with SAMPLE_DIV=4, MAX_TRIES=3, LOCK_TICKS=5, OPEN_TICKS=6.)
- Assert rst_n=0 mid-operation from state 010 -> immediate state=000, fail_cnt=0. Release -> tick at cycle 4, then every 4 cycles.
- is_on=1 -> 001. Three 1-cycle star pulses with correct=0 -> 010/fail 1, 010/fail 2, then 111 with lockout_pulse and attempts_left=0. After 5 ticks -> 000, fail_cnt=0.
- From 001, star with correct=1 -> 100 with unlock_pulse. No input -> 000 after 6 ticks.
- In 100, rekey=1 on the same tick the timer would expire -> 101. Star with correct=0 -> stays 101. Star with correct=1 -> 000 with rekey_done_pulse.
- fail_cnt=1, is_on=0 -> 000 with fail_cnt=1. is_on=1 -> 010, attempts_left=2.
- Star held high across 3 ticks -> exactly one attempt counted. initialize=1 in 111 -> 000 at next tick regardless of timer.
